// File: rtl/mips_multicycle_control_pkg.sv
// Shared types and constants for the multicycle MIPS main control FSM.
// Optional feature macro: MIPS_CTRL_BNE_EN (adds bne as a decoded branch).
package mips_multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_ALUWB_R,
        S_EXEC_I,
        S_ALUWB_I,
        S_BRANCH,
        S_JUMP
    } ctrl_state_t;

    // alu_op encodings consumed by the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    // ALU B operand select
    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // State entered after DECODE; S_FETCH means the opcode is not supported.
    function automatic ctrl_state_t decode_target(input logic [5:0] op);
        ctrl_state_t nxt;
        case (op)
            OP_LW, OP_SW:                              nxt = S_MEMADR;
            OP_RTYPE:                                  nxt = S_EXEC_R;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: nxt = S_EXEC_I;
            OP_BEQ:                                    nxt = S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
            OP_BNE:                                    nxt = S_BRANCH;
`endif
            OP_J:                                      nxt = S_JUMP;
            default:                                   nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Bus between the instruction register / datapath and the main control FSM.
// Memory handshake: a request (mem_rd or mem_wr) is held steady while the FSM
// sits in a memory state; the access completes in the cycle mem_ready is 1,
// and the FSM leaves that state on the following edge.
interface mips_multicycle_control_if;
    import mips_multicycle_control_pkg::*;

    logic [5:0]  op_code;
    logic        mem_ready;
    logic        zero;
    logic        pc_en;
    logic        iord;
    logic        mem_rd;
    logic        mem_wr;
    logic        ir_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  pc_src;
    logic        illegal_op;
    logic        mem_timeout;
    ctrl_state_t state;

    modport master (
        input  op_code, mem_ready, zero,
        output pc_en, iord, mem_rd, mem_wr, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op,
               mem_timeout, state
    );

    modport slave (
        output op_code, mem_ready, zero,
        input  pc_en, iord, mem_rd, mem_wr, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op,
               mem_timeout, state
    );
endinterface

// File: rtl/mips_multicycle_control_mem_wait_timer.sv
// Memory wait watchdog: counts stalled cycles and flags expiry combinationally
// so the FSM can abandon the access in the same cycle. MEM_TIMEOUT=0 disables.
module mips_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TIMEOUT_W   = 8
) (
    input  logic clk,
    input  logic rstb,
    input  logic waiting,
    input  logic restart,
    output logic expire
);
    localparam logic [TIMEOUT_W-1:0] LAST =
        (MEM_TIMEOUT > 0) ? TIMEOUT_W'(MEM_TIMEOUT - 1) : '0;
    localparam logic [TIMEOUT_W-1:0] SAT = '1;

    logic [TIMEOUT_W-1:0] count;

    assign expire = (MEM_TIMEOUT != 0) && waiting && (count == LAST);

    // Count stalled cycles; restart on any state change or expiry, saturate at max.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (waiting && (count != SAT)) begin
            count <= count + TIMEOUT_W'(1);
        end
    end
endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS core: sequences fetch, decode,
// execute, memory and writeback and drives the datapath enables.
// Optional feature macro: MIPS_CTRL_BNE_EN (bne branches when zero=0).
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TIMEOUT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rstb,
    mips_multicycle_control_if.master  bus
);
    ctrl_state_t state, state_next;
    logic        wait_state, waiting, restart, expire;
    logic        pc_write, branch, branch_ne;
    logic        illegal_q, timeout_q;

    assign wait_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign waiting    = wait_state && !bus.mem_ready;
    assign restart    = (state_next != state) || expire;

    mips_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TIMEOUT_W   (TIMEOUT_W)
    ) u_timer (
        .clk     (clk),
        .rstb    (rstb),
        .waiting (waiting),
        .restart (restart),
        .expire  (expire)
    );

    // State register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= S_FETCH;
        else       state <= state_next;
    end

    // Illegal-opcode pulse (one cycle after DECODE) and sticky watchdog flag.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            illegal_q <= (state == S_DECODE) && (decode_target(bus.op_code) == S_FETCH);
            timeout_q <= timeout_q | expire;
        end
    end

    // Next state and Moore outputs; FETCH write enables are gated by mem_ready.
    always_comb begin
        state_next     = state;
        pc_write       = 1'b0;
        branch         = 1'b0;
        branch_ne      = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = ALUSRCB_B;
        bus.alu_op     = ALUOP_ADD;
        bus.pc_src     = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                bus.mem_rd    = 1'b1;
                bus.alu_src_b = ALUSRCB_FOUR;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    pc_write     = 1'b1;
                    state_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.alu_src_b = ALUSRCB_IMM_SH2;
                state_next    = decode_target(bus.op_code);
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = ALUSRCB_IMM;
                if (bus.op_code == OP_SW)      state_next = S_MEMWRITE;
                else if (bus.op_code == OP_LW) state_next = S_MEMREAD;
                else                           state_next = S_FETCH;
            end
            S_MEMREAD: begin
                bus.iord   = 1'b1;
                bus.mem_rd = 1'b1;
                if (bus.mem_ready) state_next = S_MEMWB;
                else if (expire)   state_next = S_FETCH;
            end
            S_MEMWB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
                state_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.iord   = 1'b1;
                bus.mem_wr = 1'b1;
                if (bus.mem_ready || expire) state_next = S_FETCH;
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALUOP_RTYPE;
                state_next    = S_ALUWB_R;
            end
            S_ALUWB_R: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
                state_next    = S_FETCH;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = ALUSRCB_IMM;
                bus.alu_op    = ALUOP_ITYPE;
                state_next    = S_ALUWB_I;
            end
            S_ALUWB_I: begin
                bus.reg_write = 1'b1;
                state_next    = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALUOP_SUB;
                bus.pc_src    = PCSRC_ALUOUT;
`ifdef MIPS_CTRL_BNE_EN
                if (bus.op_code == OP_BNE) branch_ne = 1'b1;
                else                       branch    = 1'b1;
`else
                branch = 1'b1;
`endif
                state_next = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_src = PCSRC_JUMP;
                pc_write   = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

`ifdef MIPS_CTRL_BNE_EN
    assign bus.pc_en = pc_write | (branch & bus.zero) | (branch_ne & ~bus.zero);
`else
    assign bus.pc_en = pc_write | (branch & bus.zero) | (branch_ne & 1'b0);
`endif
    assign bus.illegal_op  = illegal_q;
    assign bus.mem_timeout = timeout_q;
    assign bus.state       = state;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: an instruction-level model expands each
// instruction into expected per-cycle control vectors and stimulus.
module tb_mips_multicycle_control;
    localparam int TO = 4;
    localparam int W  = 17;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
        logic       mem_timeout;
    } ctl_t;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4, C_BNE = 5, C_J = 6, C_ILL = 7;
    localparam logic [5:0] OP_TBL [14] = '{6'h23, 6'h2b, 6'h00, 6'h08, 6'h0a, 6'h0c, 6'h0d,
                                          6'h0e, 6'h04, 6'h05, 6'h02, 6'h3f, 6'h20, 6'h0f};

    logic clk  = 1'b0;
    logic rstb = 1'b0;

    logic [W-1:0] exp_q[$];
    logic [7:0]   stim_q[$];
    string        tag_q[$];
    int           n_cmp  = 0;
    int           n_fail = 0;
    logic         sticky_to = 1'b0;
    logic         ill_pend  = 1'b0;

    mips_multicycle_control_if bus();

    mips_multicycle_control #(.MEM_TIMEOUT(TO), .TIMEOUT_W(8)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int cls(input logic [5:0] op);
        case (op)
            6'h23: return C_LW;
            6'h2b: return C_SW;
            6'h00: return C_R;
            6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e: return C_I;
            6'h04: return C_BEQ;
`ifdef MIPS_CTRL_BNE_EN
            6'h05: return C_BNE;
`endif
            6'h02: return C_J;
            default: return C_ILL;
        endcase
    endfunction

    function automatic ctl_t idle_vec();
        ctl_t c;
        c = '0;
        c.mem_timeout = sticky_to;
        return c;
    endfunction

    function automatic ctl_t observe();
        ctl_t c;
        c.pc_en       = bus.pc_en;
        c.iord        = bus.iord;
        c.mem_rd      = bus.mem_rd;
        c.mem_wr      = bus.mem_wr;
        c.ir_write    = bus.ir_write;
        c.reg_dst     = bus.reg_dst;
        c.mem_to_reg  = bus.mem_to_reg;
        c.reg_write   = bus.reg_write;
        c.alu_src_a   = bus.alu_src_a;
        c.alu_src_b   = bus.alu_src_b;
        c.alu_op      = bus.alu_op;
        c.pc_src      = bus.pc_src;
        c.illegal_op  = bus.illegal_op;
        c.mem_timeout = bus.mem_timeout;
        return c;
    endfunction

    task automatic check(input string tag, input ctl_t e);
        ctl_t o;
        o = observe();
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s #%0d observed=%h expected=%h", tag, n_cmp, o, e);
        end
    endtask

    // Scoreboard entry: expected outputs for one cycle plus the inputs for it.
    task automatic push(input ctl_t c, input logic [5:0] op, input logic mr, input logic z, input string tag);
        exp_q.push_back(c);
        stim_q.push_back({op, mr, z});
        tag_q.push_back(tag);
    endtask

    // Instruction fetch with k stalled cycles; k >= TO abandons the fetch.
    task automatic model_fetch(input int k, output logic ok);
        ctl_t c;
        for (int i = 0; i < k && i < TO; i++) begin
            c = idle_vec();
            c.mem_rd = 1'b1; c.alu_src_b = 2'b01; c.illegal_op = ill_pend;
            ill_pend = 1'b0;
            push(c, 6'($urandom_range(0, 63)), 1'b0, rbit(), "fetch_wait");
        end
        if (k >= TO) begin
            sticky_to = 1'b1;
            ok = 1'b0;
        end else begin
            c = idle_vec();
            c.mem_rd = 1'b1; c.alu_src_b = 2'b01; c.illegal_op = ill_pend;
            c.ir_write = 1'b1; c.pc_en = 1'b1;
            ill_pend = 1'b0;
            push(c, 6'($urandom_range(0, 63)), 1'b1, rbit(), "fetch");
            ok = 1'b1;
        end
    endtask

    // Data memory access with k stalled cycles; k >= TO abandons the access.
    task automatic model_mem(input logic [5:0] op, input logic wr, input int k, output logic ok);
        ctl_t c;
        c = idle_vec();
        c.iord = 1'b1; c.mem_rd = ~wr; c.mem_wr = wr;
        for (int i = 0; i < k && i < TO; i++) push(c, op, 1'b0, rbit(), wr ? "memwrite_wait" : "memread_wait");
        if (k >= TO) begin
            sticky_to = 1'b1;
            ok = 1'b0;
        end else begin
            push(c, op, 1'b1, rbit(), wr ? "memwrite" : "memread");
            ok = 1'b1;
        end
    endtask

    task automatic model_instr(input logic [5:0] op, input int kf, input int km, input logic z);
        ctl_t c;
        int   k;
        logic ok;
        k  = kf;
        ok = 1'b0;
        while (!ok) begin
            model_fetch(k, ok);
            k = 0;
        end
        c = idle_vec(); c.alu_src_b = 2'b11;
        push(c, op, rbit(), rbit(), "decode");
        case (cls(op))
            C_LW, C_SW: begin
                c = idle_vec(); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                push(c, op, rbit(), rbit(), "memadr");
                model_mem(op, cls(op) == C_SW, km, ok);
                if (ok && cls(op) == C_LW) begin
                    c = idle_vec(); c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
                    push(c, op, rbit(), rbit(), "memwb");
                end
            end
            C_R: begin
                c = idle_vec(); c.alu_src_a = 1'b1; c.alu_op = 2'b10;
                push(c, op, rbit(), rbit(), "exec_r");
                c = idle_vec(); c.reg_dst = 1'b1; c.reg_write = 1'b1;
                push(c, op, rbit(), rbit(), "aluwb_r");
            end
            C_I: begin
                c = idle_vec(); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b11;
                push(c, op, rbit(), rbit(), "exec_i");
                c = idle_vec(); c.reg_write = 1'b1;
                push(c, op, rbit(), rbit(), "aluwb_i");
            end
            C_BEQ, C_BNE: begin
                c = idle_vec(); c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01;
                c.pc_en = (cls(op) == C_BEQ) ? z : ~z;
                push(c, op, rbit(), z, "branch");
            end
            C_J: begin
                c = idle_vec(); c.pc_src = 2'b10; c.pc_en = 1'b1;
                push(c, op, rbit(), rbit(), "jump");
            end
            default: ill_pend = 1'b1;
        endcase
    endtask

    // Driver: apply queued inputs after the edge, compare on the falling edge.
    task automatic run_cycles(input int n);
        logic [7:0] s;
        ctl_t       e;
        string      t;
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            bus.op_code   = s[7:2];
            bus.mem_ready = s[1];
            bus.zero      = s[0];
            @(negedge clk);
            check(t, e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_all();
        run_cycles(exp_q.size());
    endtask

    task automatic do_reset();
        ctl_t r;
        rstb = 1'b0;
        bus.mem_ready = 1'b0;
        sticky_to = 1'b0;
        ill_pend  = 1'b0;
        exp_q.delete(); stim_q.delete(); tag_q.delete();
        #1;
        r = idle_vec(); r.mem_rd = 1'b1; r.alu_src_b = 2'b01;
        check("reset", r);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstb = 1'b1;
    endtask

    initial begin
        ctl_t e;
        logic [5:0] op;
        bus.op_code = '0; bus.mem_ready = 1'b0; bus.zero = 1'b0;
        #2;
        do_reset();

        // Directed: lw, add, beq taken/not taken, j, illegal, bne, addi
        model_instr(6'h23, 0, 0, 1'b0); run_all();
        model_instr(6'h00, 0, 0, 1'b0); run_all();
        model_instr(6'h04, 0, 0, 1'b1); run_all();
        model_instr(6'h04, 0, 0, 1'b0); run_all();
        model_instr(6'h02, 1, 0, 1'b0); run_all();
        model_instr(6'h3f, 0, 0, 1'b0); run_all();
        model_instr(6'h08, 2, 0, 1'b0); run_all();
        model_instr(6'h05, 0, 0, 1'b1); run_all();
        model_instr(6'h05, 0, 0, 1'b0); run_all();
        model_instr(6'h2b, 0, 2, 1'b0); run_all();

        // Random instruction mix with stalls short of the watchdog limit
        for (int i = 0; i < 40; i++) begin
            op = OP_TBL[$urandom_range(0, 13)];
            model_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rbit());
            run_all();
        end

        // Watchdog expiry in FETCH, MEMREAD and MEMWRITE
        model_instr(6'h00, TO, 0, 1'b0); run_all();
        model_instr(6'h23, 0, TO, 1'b0); run_all();
        model_instr(6'h2b, 1, TO, 1'b0); run_all();
        model_instr(6'h0d, 0, 0, 1'b0); run_all();

        // Reset asserted while a store waits for memory
        do_reset();
        model_instr(6'h2b, 0, 3, 1'b0);
        run_cycles(4);
        bus.mem_ready = 1'b0;
        #2;
        e = idle_vec(); e.iord = 1'b1; e.mem_wr = 1'b1;
        check("memwrite_before_reset", e);
        do_reset();
        model_instr(6'h23, 3, 3, 1'b0); run_all();
        model_instr(6'h0e, 3, 0, 1'b0); run_all();

        // Random mix including occasional watchdog expiry
        for (int i = 0; i < 30; i++) begin
            op = OP_TBL[$urandom_range(0, 13)];
            model_instr(op, $urandom_range(0, 4), $urandom_range(0, 4), rbit());
            run_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
